// File: rtl/gf180mcu_osu_sc_bist_pkg.sv
// rtl/gf180mcu_osu_sc_bist_pkg.sv - shared states, polynomial and seed for the 12T cell BIST
package gf180mcu_osu_sc_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // x^16+x^5+x^3+x^2+1, maximal length
  localparam logic [15:0] POLY         = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] galois_step(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12T_galois16.sv
// rtl/gf180mcu_osu_sc_12T_galois16.sv - 16-bit left-shifting Galois register with load and XOR-in
module gf180mcu_osu_sc_12T_galois16
  import gf180mcu_osu_sc_bist_pkg::*;
#(
  parameter logic [15:0] RST_VAL = 16'h0000,
  parameter int          TAP_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [15:0]      i_load_val,
  input  logic [15:0]      i_xor_in,
  output logic [TAP_W-1:0] o_tap
);

  logic [15:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= RST_VAL;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_en) begin
      r_q <= galois_step(r_q) ^ i_xor_in;
    end
  end

  assign o_tap = r_q[TAP_W-1:0];

endmodule

// File: rtl/gf180mcu_osu_sc_12t_cell_bist.sv
// rtl/gf180mcu_osu_sc_12t_cell_bist.sv - LFSR stimulus, MISR compaction and golden compare for a CUT bank
module gf180mcu_osu_sc_12t_cell_bist
  import gf180mcu_osu_sc_bist_pkg::*;
#(
  parameter int          N_IN     = 8,
  parameter int          N_OUT    = 8,
  parameter int          PATTERNS = 256,
  parameter int          LAT      = 0,
  parameter logic [15:0] SEED     = DEFAULT_SEED
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic [N_IN-1:0]  STIM,
  input  logic [N_OUT-1:0] RESP,
  input  logic [15:0]      GOLDEN,
  output logic             BUSY,
  output logic             DONE,
  output logic [15:0]      SIG,
  output logic             PASS
);

  localparam logic [15:0] LAST_PAT   = 16'(PATTERNS - 1);
  localparam logic [15:0] LAST_FLUSH = (LAT > 0) ? 16'(LAT - 1) : 16'd0;

  state_t          r_state;
  state_t          w_state_next;
  logic [15:0]     r_cnt;
  logic            r_stim_on;
  logic            w_run;
  logic            w_last;
  logic            w_cap;
  logic [N_IN-1:0] w_lfsr_tap;
  logic [15:0]     w_resp_ext;
  logic [15:0]     w_sig;

  assign w_run  = (r_state == ST_RUN);
  assign w_last = w_run && (r_cnt == LAST_PAT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (START) w_state_next = ST_SEED;
      ST_SEED:  w_state_next = ST_RUN;
      ST_RUN:   if (w_last) w_state_next = (LAT > 0) ? ST_FLUSH : ST_DONE;
      ST_FLUSH: if (r_cnt == LAST_FLUSH) w_state_next = ST_DONE;
      ST_DONE:  if (START) w_state_next = ST_SEED;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // r_cnt counts patterns in RUN, then is reused to time the FLUSH window
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 16'd0;
      r_stim_on <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_stim_on <= (w_state_next == ST_RUN) || (w_state_next == ST_FLUSH);
      if ((w_run && !w_last) || (r_state == ST_FLUSH)) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= 16'd0;
      end
    end
  end

  generate
    if (LAT == 0) begin : g_nodly
      assign w_cap = w_run;
    end else begin : g_dly
      logic [LAT-1:0] r_dly;
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_dly <= '0;
        end else begin
          r_dly[0] <= w_run;
          for (int k = 1; k < LAT; k++) begin
            r_dly[k] <= r_dly[k-1];
          end
        end
      end
      assign w_cap = r_dly[LAT-1];
    end
  endgenerate

  always_comb begin
    w_resp_ext            = 16'h0000;
    w_resp_ext[N_OUT-1:0] = RESP;
  end

  // LFSR stays on the last pattern so FLUSH keeps presenting it
  gf180mcu_osu_sc_12T_galois16 #(
    .RST_VAL (SEED),
    .TAP_W   (N_IN)
  ) u_lfsr (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_en       (w_run && !w_last),
    .i_load     (r_state == ST_SEED),
    .i_load_val (SEED),
    .i_xor_in   (16'h0000),
    .o_tap      (w_lfsr_tap)
  );

  gf180mcu_osu_sc_12T_galois16 #(
    .RST_VAL (16'h0000),
    .TAP_W   (16)
  ) u_misr (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_en       (w_cap),
    .i_load     (r_state == ST_SEED),
    .i_load_val (16'h0000),
    .i_xor_in   (w_resp_ext),
    .o_tap      (w_sig)
  );

  assign STIM = r_stim_on ? w_lfsr_tap : '0;
  assign BUSY = (r_state == ST_SEED) || (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign DONE = (r_state == ST_DONE);
  assign SIG  = w_sig;
  assign PASS = DONE && (w_sig == GOLDEN);

endmodule
